// File: rtl/leaf_stream_arbiter.sv
// Round-robin merge of NUM_IN leaf valid/ready streams into one source-tagged output FIFO.
// Optional per-leaf saturating grant counters are built when LEAF_ARB_STATS_EN is defined.
module leaf_stream_arbiter #(
  parameter int NUM_IN     = 5,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int SRC_W      = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_IN-1:0]              in_valid,
  input  logic [NUM_IN*DATA_W-1:0]       in_data,
  output logic [NUM_IN-1:0]              in_ready,
  output logic                           out_valid,
  output logic [DATA_W-1:0]              out_data,
  output logic [SRC_W-1:0]               out_src,
  input  logic                           out_ready,
`ifdef LEAF_ARB_STATS_EN
  input  logic                           stats_clr,
  output logic [NUM_IN*16-1:0]           grant_cnt,
`endif
  output logic [$clog2(FIFO_DEPTH):0]    fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = SRC_W + 1;

  logic [SRC_W-1:0]  rr_ptr;
  logic [DATA_W-1:0] leaf_data [NUM_IN];

  logic              grant_vld_p0;
  logic [SRC_W-1:0]  grant_idx_p0;
  logic              can_push_p0;
  logic              push_p0;
  logic              pop_p0;
  logic [SUM_W-1:0]  cand_sum;

  logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
  logic [SRC_W-1:0]  mem_src  [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  for (genvar g = 0; g < NUM_IN; g++) begin : g_unpack
    assign leaf_data[g] = in_data[g*DATA_W +: DATA_W];
  end

  // Stage p0: rotating priority search starting at rr_ptr, then push/pop qualification.
  always_comb begin
    grant_vld_p0 = 1'b0;
    grant_idx_p0 = '0;
    cand_sum     = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      cand_sum = {1'b0, rr_ptr} + SUM_W'(k);
      if (cand_sum >= SUM_W'(NUM_IN))
        cand_sum = cand_sum - SUM_W'(NUM_IN);
      if (!grant_vld_p0 && in_valid[cand_sum[SRC_W-1:0]]) begin
        grant_vld_p0 = 1'b1;
        grant_idx_p0 = cand_sum[SRC_W-1:0];
      end
    end
  end

  assign out_valid   = (fifo_count != '0);
  assign pop_p0      = out_valid & out_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign can_push_p0 = (fifo_count < CNT_W'(FIFO_DEPTH)) | pop_p0;
  assign push_p0     = grant_vld_p0 & can_push_p0;

  always_comb begin
    in_ready = '0;
    if (push_p0)
      in_ready[grant_idx_p0] = 1'b1;
  end

  // Stage p1: FIFO storage and control state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_p0) begin
        rr_ptr <= (grant_idx_p0 == SRC_W'(NUM_IN - 1)) ? '0 : grant_idx_p0 + 1'b1;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_p0)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push_p0, pop_p0})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_p0) begin
      mem_data[wr_ptr] <= leaf_data[grant_idx_p0];
      mem_src[wr_ptr]  <= grant_idx_p0;
    end
  end

  // Head is masked while empty so stale storage never shows after reset.
  assign out_data = out_valid ? mem_data[rd_ptr] : '0;
  assign out_src  = out_valid ? mem_src[rd_ptr]  : '0;

`ifdef LEAF_ARB_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt <= '0;
    end else if (stats_clr) begin
      grant_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_IN; i++)
        if (in_ready[i])
          grant_cnt[i*16 +: 16] <= sat_inc(grant_cnt[i*16 +: 16]);
    end
  end
`endif

endmodule

// File: doc/leaf_stream_arbiter.md
Name: leaf_stream_arbiter

Overview:
- Downstream merge stage for the five leaf instances (inst_0..inst_4) of a root module.
- Collects one valid/ready data stream per leaf into a single output stream.
- Uses round-robin arbitration and a small output FIFO.
- Tags each output word with its source index so the consumer can demultiplex results.

Parameters:
- NUM_IN, 5, number of leaf input streams (2..8).
- DATA_W, 16, payload width per stream.
- FIFO_DEPTH, 4, output FIFO entries (power of two, ≥2).
- SRC_W, 3, source-tag width; must be ≥ clog2(NUM_IN).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  NUM_IN  per-leaf valid; bit i belongs to leaf i.
- in_data  input  NUM_IN*DATA_W  per-leaf payload; leaf i occupies bits [i*DATA_W +: DATA_W].
- in_ready  output  NUM_IN  per-leaf ready; at most one bit high per cycle.
- out_valid  output  1  FIFO head holds data.
- out_data  output  DATA_W  FIFO head payload.
- out_src  output  SRC_W  FIFO head source index.
- out_ready  input  1  consumer accepts the head.
- fifo_count  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Clock/reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_src=0, fifo_count=0, rr_ptr=0, FIFO pointers=0. in_ready is combinational and is therefore 0 while the FIFO is empty of requests.
- Reset mid-transfer: FIFO contents are discarded immediately. No output is asserted until new input arrives after reset deasserts.
- Transfers: an input transfer occurs on leaf i when in_valid[i] & in_ready[i]. An output transfer occurs when out_valid & out_ready.
- Arbitration (combinational):
  - Grant goes to the first index j with in_valid[j]=1, searching rr_ptr, rr_ptr+1, … modulo NUM_IN.
  - in_ready[j] = grant[j] & can_push.
  - can_push = (fifo_count < FIFO_DEPTH) | (out_valid & out_ready). A push is allowed on a full FIFO in the same cycle as a pop.
  - At most one input is accepted per cycle.
- Pointer update: on an input transfer from leaf j, rr_ptr <= (j+1) mod NUM_IN. With no transfer, rr_ptr holds. Wrap: a grant to leaf NUM_IN-1 sets rr_ptr=0.
- FIFO:
  - Each entry stores {src=j, data}.
  - A push writes at the tail; a pop advances the head.
  - out_data/out_src always present the head entry; they are registered storage, with no combinational path from in_data.
  - Latency: a word accepted in cycle N is visible at out_valid in cycle N+1 when the FIFO was empty. There is no bypass.
- Occupancy:
  - Push only: fifo_count +1.
  - Pop only: fifo_count −1.
  - Push and pop together: unchanged.
  - Pop on empty is impossible, since out_valid=0.
  - Empty and full are derived from fifo_count.
- Protocol rules:
  - A leaf must hold in_valid and in_data stable until accepted.
  - The block never drops or duplicates words.
  - With continuous out_ready=1, per-leaf ordering is preserved and global order equals grant order.
- Fairness: with all NUM_IN leaves continuously valid, each leaf is granted once every NUM_IN accepted words.
- in_valid bits at index ≥ NUM_IN do not exist; there are no unused-source encodings.

Optional Feature:
- Macro: LEAF_ARB_STATS_EN.
- When defined:
  - Adds output port grant_cnt, NUM_IN*16 bits: one saturating 16-bit counter per leaf.
  - A counter increments on each input transfer from that leaf and holds at 16'hFFFF.
  - Adds input port stats_clr (1 bit), a synchronous clear of all counters; clear wins over a simultaneous increment.
  - Counters reset to 0 on rst.
- When undefined: neither port exists, there is no counter logic, and the block's behaviour is otherwise identical.

Test Plan:
- Reset then single leaf:
  - rst high for 3 cycles, then in_valid=5'b00100 with in_data[2]=16'hA5A5 and out_ready=1.
  - Required: in_ready=5'b00100 in the same cycle; next cycle out_valid=1, out_data=16'hA5A5, out_src=2; rr_ptr becomes 3.
- Round-robin fairness:
  - All five leaves continuously valid, leaf i data = 16'h1000+i, out_ready=1, for 10 words.
  - Required: out_src sequence 0,1,2,3,4,0,1,2,3,4.
- Full / backpressure:
  - out_ready=0, leaf 1 valid with data 1..6.
  - Required: 4 accepted, fifo_count=4, in_ready=0 thereafter.
  - Then out_ready=1: data 1,2,3,4,5,6 emerge in order; simultaneous push and pop keeps fifo_count=4 while leaf 1 stays valid.
- Wrap-around:
  - rr_ptr=4 after granting leaf 3; leaves 0 and 4 both valid.
  - Required: leaf 4 granted first, then leaf 0; rr_ptr goes to 0 then 1.
- Async reset mid-operation:
  - With fifo_count=3, assert rst between clock edges.
  - Required: out_valid=0 and fifo_count=0 immediately, before the next edge; after release with no inputs, out_valid stays 0.
- Stats (LEAF_ARB_STATS_EN):
  - Feed 70000 words from leaf 0.
  - Required: grant_cnt[0]=16'hFFFF, other counters 0; stats_clr pulse → all counters 0 on the next cycle.
